reduce_nway_pipe: RTL
=====================

// Module: reduce_nway_pipe
//
// PURPOSE
//   Parametrised, pipelined N-input reduction unit; generalises the 8-way OR
//   to WIDTH inputs and four ops (OR/AND/XOR/NOR), one register per tree level.
//   Valid/ready on both sides; feeds ALU flag logic and the memory-mapped
//   status path. Throughput 1 vector/cycle; keeps a wrapping result count.
//
// PARAMETERS
//   WIDTH    8   input vector width; power of two, >= 2
//   COUNT_W  16  result counter width, >= 1
//   LEVELS   log2(WIDTH), derived localparam (not overridable): pipeline depth
//
// PORTS
//   clk        in   1        rising-edge clock
//   reset      in   1        asynchronous, active-high reset
//   in_valid   in   1        in_data/in_op valid
//   in_ready   out  1        unit accepts this cycle
//   in_data    in   WIDTH    vector to reduce
//   in_op      in   2        00 OR, 01 AND, 10 XOR, 11 NOR
//   out_valid  out  1        out_bit/out_op valid
//   out_ready  in   1        consumer accepts this cycle
//   out_bit    out  1        reduction result
//   out_op     out  2        op that produced out_bit
//   res_count  out  COUNT_W  results delivered (wrapping)
//
// BEHAVIOUR
// - Reset (async assert, sync release): all stage valids 0, out_valid 0,
//   out_bit 0, out_op 00, res_count 0, all in-flight vectors dropped.
//   in_ready 0 while reset is high.
// - Pipeline: stage k (1..LEVELS) holds WIDTH>>k partial bits, op, valid bit.
//   Stage 1 combines in_data pairs (2i, 2i+1); stage k combines stage k-1 pairs.
//   Combine fn: OR for OR/NOR, AND for AND, XOR for XOR.
//   NOR inverts only in the final stage. Op travels with its data.
// - Stage LEVELS drives out_bit/out_op/out_valid directly (registered outputs).
// - Global stall: advance = !out_valid || out_ready; in_ready = advance
//   (combinational, no comb path from in_valid). When advance = 1 every stage
//   loads from its predecessor and stage 1 loads in_data with
//   valid = in_valid; when advance = 0 every stage holds. Bubbles are not
//   compressed.
// - Accept = in_valid && in_ready. Latency: accepted at edge e, out_valid at
//   edge e+LEVELS-1 when unstalled. WIDTH = 2: out_valid after same edge.
// - Transfer = out_valid && out_ready; res_count += 1 per transfer, wraps
//   2^COUNT_W-1 -> 0.
// - Simultaneous transfer and accept: both occur; pipeline shifts by one.
// - Outputs stable while out_valid && !out_ready (AXI-style hold).
// - in_data/in_op ignored when in_valid = 0; X on them is not propagated
//   into any valid stage.
// - Reset mid-stream: items in flight are lost. First accept after release
//   emerges LEVELS edges later. res_count restarts at 0.
//
// TESTING (WIDTH=8, LEVELS=3 unless noted; out_ready=1 unless noted)
// - Ops: OR 0x00->0, OR 0x10->1, AND 0xFF->1, AND 0xFE->0, XOR 0x07->1,
//   XOR 0x03->0, NOR 0x00->1, NOR 0x80->0. Each result arrives 3 edges after
//   accept, and out_op echoes the op.
// - Back-to-back: 8 vectors on consecutive cycles -> 8 consecutive results
//   in order, no gaps; res_count = 8.
// - Backpressure: 3 in flight, hold out_ready=0 for 5 cycles -> out_bit/op
//   held, in_ready=0, no loss or duplication. Release -> 3 results in order.
// - Reset mid-flight with 2 items in flight -> out_valid=0 and res_count=0
//   immediately. Next vector arrives 3 edges after release+accept.
// - COUNT_W=4: 17 transfers -> res_count reads 1 (wrap observed at 16 -> 0).
// - WIDTH=2 and WIDTH=32: exhaustive (2) / random (1000) vectors vs reference
//   reduction model, latency 1 and 5 respectively.

Source files
------------

// File: rtl/reduce_nway_pipe_if.sv
// reduce_nway_pipe_if: input/output valid-ready streams and result counter of the reduction unit
interface reduce_nway_pipe_if #(
    parameter int WIDTH   = 8,
    parameter int COUNT_W = 16
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic [1:0]         in_op;
    logic               out_valid;
    logic               out_ready;
    logic               out_bit;
    logic [1:0]         out_op;
    logic [COUNT_W-1:0] res_count;

    modport master (
        output in_valid, in_data, in_op, out_ready,
        input  in_ready, out_valid, out_bit, out_op, res_count
    );

    modport slave (
        input  in_valid, in_data, in_op, out_ready,
        output in_ready, out_valid, out_bit, out_op, res_count
    );
endinterface

// File: rtl/reduce_nway_pipe.sv
// reduce_nway_pipe: pipelined WIDTH-input OR/AND/XOR/NOR reduction tree, one register per level
module reduce_nway_pipe #(
    parameter int WIDTH   = 8,
    parameter int COUNT_W = 16
) (
    input logic               clk,
    input logic               reset,
    reduce_nway_pipe_if.slave bus
);
    localparam int LEVELS = $clog2(WIDTH);
    localparam int NODES  = 2 * WIDTH - 1;

    // node packs the gated input vector (level 0) below all registered levels;
    // level k starts at 2*WIDTH - (2*WIDTH >> k) and is WIDTH >> k bits wide
    logic                   advance;
    logic [NODES-1:0]       node;
    logic [WIDTH-2:0]       comb_tree, tree_d, tree_q;
    logic [LEVELS:0][1:0]   op_n;
    logic [LEVELS-1:0][1:0] op_d, op_q;
    logic [LEVELS:0]        valid_n;
    logic [LEVELS-1:0]      valid_d, valid_q;
    logic [COUNT_W-1:0]     count_d, count_q;

    assign advance = !valid_q[LEVELS-1] || bus.out_ready;
    assign node    = {tree_q, bus.in_valid ? bus.in_data : {WIDTH{1'b0}}};
    assign op_n    = {op_q, bus.in_valid ? bus.in_op : 2'b00};
    assign valid_n = {valid_q, bus.in_valid};

    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        for (genvar i = 0; i < (WIDTH >> (k + 1)); i++) begin : g_bit
            localparam int SRC = 2 * WIDTH - ((2 * WIDTH) >> k) + 2 * i;
            localparam int DST = WIDTH - ((2 * WIDTH) >> (k + 1)) + i;
            logic f;
            assign f = op_n[k] == 2'b01 ? node[SRC] & node[SRC+1] :
                       op_n[k] == 2'b10 ? node[SRC] ^ node[SRC+1] :
                                          node[SRC] | node[SRC+1];
            assign comb_tree[DST] = (k == LEVELS - 1 && op_n[k] == 2'b11) ? ~f : f;
        end
    end

    assign bus.in_ready  = advance && !reset;
    assign bus.out_valid = valid_q[LEVELS-1];
    assign bus.out_bit   = tree_q[WIDTH-2];
    assign bus.out_op    = op_q[LEVELS-1];
    assign bus.res_count = count_q;

    // whole pipeline shifts one level on advance, otherwise every level holds
    always_comb begin
        tree_d  = advance ? comb_tree : tree_q;
        op_d    = advance ? op_n[LEVELS-1:0] : op_q;
        valid_d = advance ? valid_n[LEVELS-1:0] : valid_q;
        count_d = count_q + COUNT_W'(valid_q[LEVELS-1] && bus.out_ready);
    end

    // pipeline and counter registers, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tree_q  <= '0;
            op_q    <= '0;
            valid_q <= '0;
            count_q <= '0;
        end else begin
            tree_q  <= tree_d;
            op_q    <= op_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end
endmodule
